// File: rtl/mem_request_responder_pkg.sv
// Shared types for the memory request responder: bus word, RAM handshake state,
// responder FSM state and the word returned when an access is aborted.
package mem_request_responder_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        INSTR,
        DRESP,
        IRESP
    } resp_state_t;

    // Returned in the load register when an access times out or the RAM reports ERROR.
    localparam word_t BAD_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/mem_request_responder_if.sv
// Request-unit and RAM-side signals of the memory responder bundled together.
// slave is the responder's view, master is the view of whatever drives it.
interface mem_request_responder_if;
    import mem_request_responder_pkg::*;

    // request unit side
    logic      imemREN;
    word_t     imemaddr;
    logic      dmemREN;
    logic      dmemWEN;
    word_t     dmemaddr;
    word_t     dmemstore;
    logic      ihit;
    logic      dhit;
    word_t     imemload;
    word_t     dmemload;

    // RAM side
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    // status
    logic      bus_err;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  ramload, ramstate,
        output ihit, dhit, imemload, dmemload,
        output ramREN, ramWEN, ramaddr, ramstore, bus_err
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
        output ramload, ramstate,
        input  ihit, dhit, imemload, dmemload,
        input  ramREN, ramWEN, ramaddr, ramstore, bus_err
    );

endinterface

// File: rtl/mem_request_responder_access_timer.sv
// Wait counter for one RAM access: cleared outside an access, counts cycles spent
// waiting for ACCESS, flags expiry on the last allowed cycle. Saturates, never wraps.
module mem_request_responder_access_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW        = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST      = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] COUNT_MAX = '1;

    logic [CW-1:0] count_reg;

    // Count waiting cycles; hold at the top value rather than wrap back to zero.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != COUNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/mem_request_responder.sv
// Memory-side responder: arbitrates the single RAM port between instruction and
// data requests (data first, no preemption) and returns registered one-cycle hits.
module mem_request_responder
    import mem_request_responder_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input logic                    CLK,
    input logic                    nRST,
    mem_request_responder_if.slave bus
);

    resp_state_t state_reg;
    logic        ihit_reg;
    logic        dhit_reg;
    logic        bus_err_reg;
    word_t       imemload_reg;
    word_t       dmemload_reg;

    logic        data_req;
    logic        in_access;
    logic        timer_clear;
    logic        timer_enable;
    logic        timer_expired;
    logic        abort;

    assign data_req     = bus.dmemREN | bus.dmemWEN;
    assign in_access    = (state_reg == DATA) || (state_reg == INSTR);
    // Clearing in every non-access state means each access starts from zero.
    assign timer_clear  = ~in_access;
    assign timer_enable = in_access && (bus.ramstate != ACCESS);
    assign abort        = (bus.ramstate == ERROR) || timer_expired;

    mem_request_responder_access_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_access_timer (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Responder FSM with registered hits, load words and sticky error flag.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg    <= IDLE;
            ihit_reg     <= 1'b0;
            dhit_reg     <= 1'b0;
            bus_err_reg  <= 1'b0;
            imemload_reg <= '0;
            dmemload_reg <= '0;
        end else begin
            ihit_reg <= 1'b0;
            dhit_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (data_req) begin
                        state_reg <= DATA;
                    end else if (bus.imemREN) begin
                        state_reg <= INSTR;
                    end
                end
                DATA: begin
                    // A withdrawn request is dropped silently, even if ACCESS arrives now.
                    if (!data_req) begin
                        state_reg <= IDLE;
                    end else if (bus.ramstate == ACCESS) begin
                        if (!bus.dmemWEN) begin
                            dmemload_reg <= bus.ramload;
                        end
                        dhit_reg  <= 1'b1;
                        state_reg <= DRESP;
                    end else if (abort) begin
                        // Still answer with a hit so the requester cannot hang.
                        bus_err_reg  <= 1'b1;
                        dmemload_reg <= BAD_WORD;
                        dhit_reg     <= 1'b1;
                        state_reg    <= DRESP;
                    end
                end
                INSTR: begin
                    if (!bus.imemREN) begin
                        state_reg <= IDLE;
                    end else if (bus.ramstate == ACCESS) begin
                        imemload_reg <= bus.ramload;
                        ihit_reg     <= 1'b1;
                        state_reg    <= IRESP;
                    end else if (abort) begin
                        bus_err_reg  <= 1'b1;
                        imemload_reg <= BAD_WORD;
                        ihit_reg     <= 1'b1;
                        state_reg    <= IRESP;
                    end
                end
                DRESP, IRESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // RAM port mux: driven only while an access is in flight, zero otherwise.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (state_reg)
            DATA: begin
                bus.ramaddr  = bus.dmemaddr;
                bus.ramstore = bus.dmemstore;
                // A write takes the port when both data enables are up.
                bus.ramWEN   = bus.dmemWEN;
                bus.ramREN   = bus.dmemREN & ~bus.dmemWEN;
            end
            INSTR: begin
                bus.ramaddr = bus.imemaddr;
                bus.ramREN  = bus.imemREN;
            end
            default: begin
            end
        endcase
    end

    assign bus.ihit     = ihit_reg;
    assign bus.dhit     = dhit_reg;
    assign bus.imemload = imemload_reg;
    assign bus.dmemload = dmemload_reg;
    assign bus.bus_err  = bus_err_reg;

endmodule

// File: tb/tb_mem_request_responder.sv
// Bench for mem_request_responder: table of single accesses plus hand-written
// sequences for arbitration, withdrawal, mid-access reset and timeout.
module tb_mem_request_responder;
    import mem_request_responder_pkg::*;

    localparam int TB_TIMEOUT = 8;
    localparam int K_IREAD  = 0;
    localparam int K_DREAD  = 1;
    localparam int K_DWRITE = 2;
    localparam int K_DBOTH  = 3;
    localparam int NV       = 7;

    typedef struct {
        int    kind;
        word_t addr;
        word_t store;
        int    busy;
        word_t rload;
        word_t exp_load;
        logic  exp_ren;
        logic  exp_wen;
        logic  err;
    } vec_t;

    typedef struct {
        logic  is_instr;
        word_t load;
    } sb_t;

    logic clk = 1'b0;
    logic nrst;
    int   checks = 0;
    int   failures = 0;
    int   txn_n = 0;
    sb_t  sb_q[$];
    vec_t vecs[NV];
    vec_t fresh;

    mem_request_responder_if bus_if ();

    mem_request_responder #(
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Advance one cycle; at mid-cycle pop the scoreboard for any hit seen.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (bus_if.ihit || bus_if.dhit) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_hit actual ihit=%b dhit=%b required none",
                         bus_if.ihit, bus_if.dhit);
            end else begin
                e = sb_q.pop_front();
                chkb("hit_ihit", bus_if.ihit, e.is_instr);
                chkb("hit_dhit", bus_if.dhit, ~e.is_instr);
                chk("hit_load", e.is_instr ? bus_if.imemload : bus_if.dmemload, e.load);
                $display("txn %0d: %s hit imemload=%h dmemload=%h bus_err=%b",
                         txn_n, e.is_instr ? "instr" : "data",
                         bus_if.imemload, bus_if.dmemload, bus_if.bus_err);
                txn_n++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // One complete access from IDLE: request, BUSY cycles, ACCESS/ERROR, hit.
    task automatic run_vec(input vec_t v, input int idx);
        word_t exp_store;
        sb_t   e;
        bus_if.imemREN   = (v.kind == K_IREAD);
        bus_if.dmemREN   = (v.kind == K_DREAD) || (v.kind == K_DBOTH);
        bus_if.dmemWEN   = (v.kind == K_DWRITE) || (v.kind == K_DBOTH);
        bus_if.dmemstore = v.store;
        if (v.kind == K_IREAD) bus_if.imemaddr = v.addr;
        else                   bus_if.dmemaddr = v.addr;
        exp_store  = (v.kind == K_IREAD) ? 32'h0 : v.store;
        e.is_instr = (v.kind == K_IREAD);
        e.load     = v.exp_load;
        sb_q.push_back(e);
        tick();
        chk($sformatf("v%0d_ramaddr", idx), bus_if.ramaddr, v.addr);
        chkb($sformatf("v%0d_ramREN", idx), bus_if.ramREN, v.exp_ren);
        chkb($sformatf("v%0d_ramWEN", idx), bus_if.ramWEN, v.exp_wen);
        chk($sformatf("v%0d_ramstore", idx), bus_if.ramstore, exp_store);
        bus_if.ramload = v.rload;
        for (int c = 0; c < v.busy; c++) begin
            bus_if.ramstate = BUSY;
            chkb($sformatf("v%0d_early_hit", idx), bus_if.ihit | bus_if.dhit, 1'b0);
            tick();
        end
        bus_if.ramstate = v.err ? ERROR : ACCESS;
        tick();
        bus_if.ramstate = FREE;
        chkb($sformatf("v%0d_hit", idx),
             (v.kind == K_IREAD) ? bus_if.ihit : bus_if.dhit, 1'b1);
        chkb($sformatf("v%0d_resp_en", idx), bus_if.ramREN | bus_if.ramWEN, 1'b0);
        chkb($sformatf("v%0d_bus_err", idx), bus_if.bus_err, v.err);
        bus_if.imemREN = 1'b0;
        bus_if.dmemREN = 1'b0;
        bus_if.dmemWEN = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{K_IREAD,  32'h40,  32'h12340000, 3, 32'h8C220004, 32'h8C220004, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{K_DREAD,  32'h100, 32'h00000000, 0, 32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{K_DBOTH,  32'h104, 32'hDEADBEEF, 1, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{K_DWRITE, 32'h200, 32'hCAFEF00D, 2, 32'h00000000, 32'h12345678, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{K_IREAD,  32'h44,  32'hAAAA5555, 1, 32'h00000013, 32'h00000013, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{K_DREAD,  32'h108, 32'h00000000, 5, 32'hA5A55A5A, 32'hA5A55A5A, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{K_IREAD,  32'h48,  32'h00000000, 1, 32'h99999999, BAD_WORD,     1'b1, 1'b0, 1'b1};
        fresh   = '{K_DREAD,  32'h604, 32'h0F0F0F0F, 2, 32'h5555AAAA, 32'h5555AAAA, 1'b1, 1'b0, 1'b0};

        nrst             = 1'b0;
        bus_if.imemREN   = 1'b0;
        bus_if.imemaddr  = '0;
        bus_if.dmemREN   = 1'b0;
        bus_if.dmemWEN   = 1'b0;
        bus_if.dmemaddr  = '0;
        bus_if.dmemstore = '0;
        bus_if.ramload   = '0;
        bus_if.ramstate  = FREE;
        repeat (3) tick();

        // reset state
        chkb("rst_ihit", bus_if.ihit, 1'b0);
        chkb("rst_dhit", bus_if.dhit, 1'b0);
        chkb("rst_ramREN", bus_if.ramREN, 1'b0);
        chkb("rst_ramWEN", bus_if.ramWEN, 1'b0);
        chk("rst_ramaddr", bus_if.ramaddr, 32'h0);
        chk("rst_imemload", bus_if.imemload, 32'h0);
        chk("rst_dmemload", bus_if.dmemload, 32'h0);
        chkb("rst_bus_err", bus_if.bus_err, 1'b0);
        nrst = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // reset while a data read is waiting
        bus_if.dmemaddr  = 32'h600;
        bus_if.dmemstore = 32'h0F0F0F0F;
        bus_if.dmemREN   = 1'b1;
        tick();
        bus_if.ramstate = BUSY;
        chkb("mrst_ramREN_before", bus_if.ramREN, 1'b1);
        nrst = 1'b0;
        tick();
        chkb("mrst_ramREN", bus_if.ramREN, 1'b0);
        chkb("mrst_ramWEN", bus_if.ramWEN, 1'b0);
        chk("mrst_ramaddr", bus_if.ramaddr, 32'h0);
        chk("mrst_ramstore", bus_if.ramstore, 32'h0);
        chkb("mrst_dhit", bus_if.dhit, 1'b0);
        chk("mrst_imemload", bus_if.imemload, 32'h0);
        chk("mrst_dmemload", bus_if.dmemload, 32'h0);
        chkb("mrst_bus_err", bus_if.bus_err, 1'b0);
        nrst            = 1'b1;
        bus_if.dmemREN  = 1'b0;
        bus_if.ramstate = FREE;
        tick();
        run_vec(fresh, 100);

        // simultaneous requests: data first, then instruction
        bus_if.imemaddr = 32'h80;
        bus_if.dmemaddr = 32'h300;
        bus_if.imemREN  = 1'b1;
        bus_if.dmemREN  = 1'b1;
        bus_if.dmemWEN  = 1'b0;
        sb_q.push_back('{1'b0, 32'h11112222});
        sb_q.push_back('{1'b1, 32'h33334444});
        tick();
        chk("sim_data_addr", bus_if.ramaddr, 32'h300);
        chkb("sim_data_ren", bus_if.ramREN, 1'b1);
        bus_if.ramload  = 32'h11112222;
        bus_if.ramstate = ACCESS;
        tick();
        bus_if.ramstate = FREE;
        chkb("sim_dhit", bus_if.dhit, 1'b1);
        chkb("sim_no_ihit", bus_if.ihit, 1'b0);
        bus_if.dmemREN = 1'b0;
        tick();
        chkb("sim_idle_ren", bus_if.ramREN, 1'b0);
        tick();
        chk("sim_instr_addr", bus_if.ramaddr, 32'h80);
        bus_if.ramload  = 32'h33334444;
        bus_if.ramstate = ACCESS;
        tick();
        bus_if.ramstate = FREE;
        chkb("sim_ihit", bus_if.ihit, 1'b1);
        bus_if.imemREN = 1'b0;
        tick();

        // withdrawal while waiting; ACCESS in the withdrawal cycle must not latch
        bus_if.dmemaddr = 32'h500;
        bus_if.dmemREN  = 1'b1;
        tick();
        bus_if.ramstate = BUSY;
        tick();
        bus_if.dmemREN  = 1'b0;
        bus_if.ramstate = ACCESS;
        bus_if.ramload  = 32'h77777777;
        tick();
        bus_if.ramstate = FREE;
        chkb("wd_ramREN", bus_if.ramREN, 1'b0);
        chkb("wd_ramWEN", bus_if.ramWEN, 1'b0);
        chkb("wd_dhit", bus_if.dhit, 1'b0);
        chk("wd_ramaddr", bus_if.ramaddr, 32'h0);
        chk("wd_dmemload", bus_if.dmemload, 32'h11112222);
        tick();
        tick();

        // timeout with ramstate held BUSY
        chkb("to_bus_err_before", bus_if.bus_err, 1'b0);
        bus_if.dmemaddr = 32'h400;
        bus_if.dmemREN  = 1'b1;
        sb_q.push_back('{1'b0, BAD_WORD});
        tick();
        bus_if.ramstate = BUSY;
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            chkb($sformatf("to_wait_dhit_%0d", k), bus_if.dhit, 1'b0);
            tick();
        end
        chkb("to_dhit", bus_if.dhit, 1'b1);
        chkb("to_bus_err", bus_if.bus_err, 1'b1);
        bus_if.dmemREN  = 1'b0;
        bus_if.ramstate = FREE;
        tick();
        tick();
        tick();
        chkb("to_bus_err_sticky", bus_if.bus_err, 1'b1);

        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
